ahb_bus_arbiter: RTL and testbench

//  Arbitrates the shared AHB bus between the two CPU-side masters: M1 (IM fetch) and M2 (DM load/store).

---
 rtl/ahb_bus_arbiter.sv | 119 +++++++++++
 tb/tb_ahb_bus_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ahb_bus_arbiter.sv
// Two-master AHB arbiter (M1 fetch, M2 load/store): registered one-hot grants, address/data-phase owner, lock, beat-bounded tenure.
// Optional build macro ARB_ROUND_ROBIN_EN: on hold-limit contention the master not owning the last tenure wins (default: M2 wins).
module ahb_bus_arbiter #(
  parameter int DEFAULT_MASTER = 1,
  parameter int HOLD_LIMIT     = 16,
  parameter int CNT_W          = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       HBUSREQ_M1,
  input  logic       HBUSREQ_M2,
  input  logic       HLOCK_M1,
  input  logic       HLOCK_M2,
  input  logic [1:0] HTRANS,
  input  logic       HREADY,
  output logic       HGRANT_M1,
  output logic       HGRANT_M2,
  output logic [1:0] HMASTER,
  output logic [1:0] HMASTER_D,
  output logic       HMASTLOCK
);

  typedef enum logic {GNT_M1 = 1'b0, GNT_M2 = 1'b1} gnt_e;

  localparam gnt_e             RST_GNT = (DEFAULT_MASTER == 2) ? GNT_M2 : GNT_M1;
  localparam logic [1:0]       RST_MST = (DEFAULT_MASTER == 2) ? 2'd2 : 2'd1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_LIMIT - 1);

  gnt_e             state_q, state_d;
  logic [1:0]       hmaster_q, hmaster_d;
  logic [1:0]       downer_q, downer_d;
  logic             mlock_q, mlock_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
  gnt_e             last_owner_q, last_owner_d;
`endif

  logic owner_req, owner_lock, other_req, beat, rearb;
  gnt_e winner;

  always_comb begin
    owner_req  = (state_q == GNT_M2) ? HBUSREQ_M2 : HBUSREQ_M1;
    owner_lock = (state_q == GNT_M2) ? HLOCK_M2   : HLOCK_M1;
    other_req  = (state_q == GNT_M2) ? HBUSREQ_M1 : HBUSREQ_M2;
    beat       = HREADY && ((HTRANS == 2'b10) || (HTRANS == 2'b11));
    rearb      = HREADY && !owner_lock &&
                 (!owner_req || ((beat_cnt_q == CNT_MAX) && beat && other_req));

    winner = RST_GNT;
    if (HBUSREQ_M1 && HBUSREQ_M2) begin
`ifdef ARB_ROUND_ROBIN_EN
      winner = (last_owner_q == GNT_M1) ? GNT_M2 : GNT_M1;
`else
      winner = GNT_M2;
`endif
    end else if (HBUSREQ_M1) begin
      winner = GNT_M1;
    end else if (HBUSREQ_M2) begin
      winner = GNT_M2;
    end
  end

  always_comb begin
    state_d    = state_q;
    hmaster_d  = hmaster_q;
    downer_d   = downer_q;
    mlock_d    = mlock_q;
    beat_cnt_d = beat_cnt_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_owner_d = last_owner_q;
`endif
    if (rearb) begin
      state_d = winner;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner_d = winner;
`endif
    end
    // Address and data owners advance together so the old owner's data phase finishes under HMASTER_D.
    if (HREADY) begin
      hmaster_d = (state_d == GNT_M2) ? 2'd2 : 2'd1;
      downer_d  = hmaster_q;
      mlock_d   = (state_d == GNT_M2) ? HLOCK_M2 : HLOCK_M1;
      if (state_d != state_q) begin
        beat_cnt_d = '0;
      end else if (beat && (beat_cnt_q != CNT_MAX)) begin
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RST_GNT;
      hmaster_q  <= RST_MST;
      downer_q   <= RST_MST;
      mlock_q    <= 1'b0;
      beat_cnt_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner_q <= RST_GNT;
`endif
    end else begin
      state_q    <= state_d;
      hmaster_q  <= hmaster_d;
      downer_q   <= downer_d;
      mlock_q    <= mlock_d;
      beat_cnt_q <= beat_cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  assign HGRANT_M1 = (state_q == GNT_M1);
  assign HGRANT_M2 = (state_q == GNT_M2);
  assign HMASTER   = hmaster_q;
  assign HMASTER_D = downer_q;
  assign HMASTLOCK = mlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Bench for ahb_bus_arbiter: directed vector table, hand sequences for wait/lock/hold/reset, random run against a tenure-level model.
module tb_ahb_bus_arbiter;
  localparam int HOLD = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req1 = 0, req2 = 0, lock1 = 0, lock2 = 0, ready = 1;
  logic [1:0] htrans = 2'd0;
  logic       g1, g2, mlock;
  logic [1:0] hm, hmd;

  int total = 0;
  int bad = 0;

  // Reference model state: plain integers, masters numbered 1 and 2.
  int  m_owner, m_cnt, m_hm, m_hmd, m_last;
  bit  m_lock;

  always #5 clk = ~clk;

  ahb_bus_arbiter #(.DEFAULT_MASTER(1), .HOLD_LIMIT(HOLD), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .HBUSREQ_M1(req1), .HBUSREQ_M2(req2),
    .HLOCK_M1(lock1), .HLOCK_M2(lock2),
    .HTRANS(htrans), .HREADY(ready),
    .HGRANT_M1(g1), .HGRANT_M2(g2),
    .HMASTER(hm), .HMASTER_D(hmd), .HMASTLOCK(mlock)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 1; m_cnt = 0; m_hm = 1; m_hmd = 1; m_lock = 0; m_last = 1;
  endtask

  task automatic model_edge();
    bit rq[3];
    bit lk[3];
    int other, nxt;
    bit beat, limit_hit;
    if (!ready) return;
    rq[1] = req1; rq[2] = req2; lk[1] = lock1; lk[2] = lock2; rq[0] = 0; lk[0] = 0;
    other = 3 - m_owner;
    beat = (htrans >= 2);
    limit_hit = beat && (m_cnt == HOLD - 1) && rq[other];
    nxt = m_owner;
    if (!lk[m_owner] && (!rq[m_owner] || limit_hit)) begin
      if (rq[1] && rq[2]) begin
`ifdef ARB_ROUND_ROBIN_EN
        nxt = 3 - m_last;
`else
        nxt = 2;
`endif
      end else if (rq[1]) nxt = 1;
      else if (rq[2]) nxt = 2;
      else nxt = 1;
      m_last = nxt;
    end
    m_hmd = m_hm;
    m_hm = nxt;
    m_lock = lk[nxt];
    if (nxt != m_owner) m_cnt = 0;
    else if (beat && m_cnt < HOLD - 1) m_cnt++;
    m_owner = nxt;
  endtask

  task automatic chk_model();
    chk("gnt_m1", g1, m_owner == 1);
    chk("gnt_m2", g2, m_owner == 2);
    chk("hmaster", hm, m_hm);
    chk("hmaster_d", hmd, m_hmd);
    chk("hmastlock", mlock, m_lock);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk_model();
  endtask

  task automatic drive(input bit r1, input bit r2, input bit l1, input bit l2,
                       input logic [1:0] t, input bit rdy);
    req1 = r1; req2 = r2; lock1 = l1; lock2 = l2; htrans = t; ready = rdy;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_gnt_m1", g1, 1);
    chk("rst_gnt_m2", g2, 0);
    chk("rst_hmaster", hm, 1);
    chk("rst_hmaster_d", hmd, 1);
    chk("rst_hmastlock", mlock, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit r1, r2, l1, l2; logic [1:0] t; bit rdy;
    bit e_g1, e_g2; int e_hm, e_hmd; bit e_lk;
  } vec_t;

  vec_t vt[13];

  initial begin
    vt[0]  = '{0,0,0,0,2'd0,1, 1,0,1,1,0};
    vt[1]  = '{0,1,0,0,2'd0,1, 0,1,2,1,0};
    vt[2]  = '{0,1,0,0,2'd2,1, 0,1,2,2,0};
    vt[3]  = '{1,0,0,0,2'd0,0, 0,1,2,2,0};
    vt[4]  = '{1,0,0,0,2'd0,0, 0,1,2,2,0};
    vt[5]  = '{1,0,0,0,2'd0,0, 0,1,2,2,0};
    vt[6]  = '{1,0,0,0,2'd0,1, 1,0,1,2,0};
    vt[7]  = '{1,0,1,0,2'd2,1, 1,0,1,1,1};
    vt[8]  = '{0,1,1,0,2'd3,1, 1,0,1,1,1};
    vt[9]  = '{0,1,0,0,2'd0,1, 0,1,2,1,0};
    vt[10] = '{0,1,0,1,2'd3,1, 0,1,2,2,1};
    vt[11] = '{0,0,0,0,2'd0,1, 1,0,1,2,0};
    vt[12] = '{1,1,0,0,2'd0,1, 1,0,1,1,0};

    model_reset();
    #12;
    do_reset();

    // Directed table: park, switch, wait states, lock handover, return to park.
    for (int i = 0; i < 13; i++) begin
      drive(vt[i].r1, vt[i].r2, vt[i].l1, vt[i].l2, vt[i].t, vt[i].rdy);
      step();
      chk($sformatf("vec%0d_g1", i), g1, vt[i].e_g1);
      chk($sformatf("vec%0d_g2", i), g2, vt[i].e_g2);
      chk($sformatf("vec%0d_hm", i), hm, vt[i].e_hm);
      chk($sformatf("vec%0d_hmd", i), hmd, vt[i].e_hmd);
      chk($sformatf("vec%0d_lk", i), mlock, vt[i].e_lk);
    end

    // Hold limit: both request a SEQ stream from a fresh M1 tenure; switch after the 16th beat.
    do_reset();
    drive(1, 1, 0, 0, 2'd3, 1);
    for (int i = 1; i < HOLD; i++) begin
      step();
      chk($sformatf("hold_keep%0d", i), g1, 1);
    end
    step();
    chk("hold_switch_g2", g2, 1);
    chk("hold_switch_hm", hm, 2);
`ifndef ARB_ROUND_ROBIN_EN
    for (int i = 0; i < 20; i++) step();
    chk("hold_fixed_prio_g2", g2, 1);
`endif

    // Lock: 20 locked beats with M2 waiting, then release.
    do_reset();
    drive(1, 1, 1, 0, 2'd3, 1);
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("lock_keep%0d", i), g1, 1);
      chk($sformatf("lock_mlk%0d", i), mlock, 1);
    end
    drive(0, 1, 0, 0, 2'd0, 1);
    step();
    chk("lock_release_g2", g2, 1);
    chk("lock_release_mlk", mlock, 0);

    // Async reset in the middle of an M2 SEQ beat, then counter restarts from zero.
    drive(0, 1, 0, 0, 2'd3, 1);
    step();
    step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_g1", g1, 1);
    chk("arst_g2", g2, 0);
    chk("arst_hm", hm, 1);
    chk("arst_hmd", hmd, 1);
    chk("arst_lk", mlock, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 1, 0, 0, 2'd3, 1);
    for (int i = 1; i < HOLD; i++) step();
    chk("arst_cnt_keep", g1, 1);
    step();
    chk("arst_cnt_switch", g2, 1);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
            2'($urandom_range(0, 3)), $urandom_range(0, 4) != 0);
      step();
      chk("onehot", int'(g1) + int'(g2), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
